calc_ctrl: RTL and testbench
============================

# calc_ctrl

Sequencing controller for the keypad calculator. It consumes the validated key events from the keypad interface and assembles decimal operands A and B into binary. It launches the shared ALU through a start/done handshake and drives the display value and error flag. It sits between the keypad front-end and the arithmetic datapath, and is the only block that issues ALU commands.

## Interface
- `W`, 16, operand/result width in bits (unsigned).
- `MAX_DIGITS`, 4, maximum decimal digits per operand. Constraint: 10^MAX_DIGITS − 1 < 2^W.
- `TIMEOUT`, 1024, maximum cycles to wait for `alu_done` before declaring an error.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `key_valid`  in  1  one-cycle pulse; key class and value inputs are valid in this cycle.
- `is_number`  in  1  key is a digit.
- `is_op`  in  1  key is an operator.
- `is_eq`  in  1  key is "=".
- `num_val`  in  4  digit value, 0–9.
- `op_val`  in  2  operator: 0 add, 1 sub, 2 mul, 3 reserved.
- `alu_start`  out  1  one-cycle launch pulse.
- `alu_a`, `alu_b`  out  W  operands; held stable from `alu_start` until `alu_done`.
- `alu_op`  out  2  operation code; held with the operands.
- `alu_done`  in  1  one-cycle pulse; `alu_result`/`alu_ovf` are valid in this cycle.
- `alu_result`  in  W  ALU result.
- `alu_ovf`  in  1  overflow or underflow (sub borrow, mul > 2^W − 1).
- `disp_val`  out  W  value to display.
- `disp_err`  out  1  error indicator.
- `busy`  out  1  high while in S_WAIT.

## Operation
- States: S_A (entering A), S_OP (operator latched, B not started), S_B (entering B), S_WAIT (ALU running), S_RES (result shown), S_ERR.
- Key decode: when `key_valid` is high, class priority is `is_number` > `is_op` > `is_eq`.
  - A key with no class set is ignored.
  - A digit with `num_val` > 9 is ignored.
  - An operator with `op_val` = 3 is ignored.
- Digit append: `opnd <= opnd*10 + num_val`, computed at W+4 bits and truncated to W. The digit counter increments.
  - If the counter is already `MAX_DIGITS`, the digit is dropped.
- S_A:
  - digit → append to A; `disp_val` = A.
  - op → latch op → S_OP.
  - eq → ignored.
- S_OP:
  - digit → B = digit, count = 1, `disp_val` = B → S_B.
  - op → replaces the latched op.
  - eq → ignored.
- S_B:
  - digit → append to B; `disp_val` = B.
  - eq → launch the ALU → S_WAIT with chain = 0.
  - op → launch the ALU, store the new op as pending → S_WAIT with chain = 1.
- S_WAIT:
  - All keys are dropped; they are not queued.
  - The timeout counter increments each cycle.
  - `alu_done` with `alu_ovf` = 1 → S_ERR.
  - `alu_done` with `alu_ovf` = 0 → A = `alu_result`, `disp_val` = result, digit count = 0. Then chain = 1 → op = pending, go to S_OP; chain = 0 → S_RES.
  - Counter reaches `TIMEOUT` with no done → S_ERR.
- S_RES:
  - digit → A = digit, count = 1 → S_A (new computation).
  - op → latch op → S_OP (result becomes A).
  - eq → ignored.
- S_ERR:
  - `disp_err` = 1, `disp_val` = 0.
  - digit → clear error, A = digit, count = 1 → S_A.
  - Other keys are ignored.
- `alu_done` outside S_WAIT is ignored.
- Reset values:
  - State S_A; A, B, digit count, timeout counter and chain = 0.
  - `alu_start` = 0, `alu_a` = 0, `alu_b` = 0, `alu_op` = 0.
  - `disp_val` = 0, `disp_err` = 0, `busy` = 0.
- Reset asserted mid-operation, including in S_WAIT, returns to the reset values on the next edge. A later stale `alu_done` is ignored.

## Timing
- Key accepted at edge N: state, operand and `disp_val` update at edge N+1 (1-cycle latency).
- ALU launch:
  - `alu_start` is high for exactly the cycle after the "=" or chaining operator is sampled.
  - `alu_a`, `alu_b` and `alu_op` are valid in that same cycle.
  - `busy` rises with `alu_start`.
- Done handling:
  - `alu_done` sampled at edge M: `disp_val`/`disp_err` and state update at M+1.
  - `busy` is low from M+1.
  - A key arriving in the same cycle as `alu_done` is dropped.
- `alu_done` in the same cycle as `alu_start`: not legal for the ALU; undefined.
- Timeout: S_ERR is entered at the `TIMEOUT`-th cycle after `alu_start` if no done has been sampled.

## Test plan
- Reset → all outputs 0, state S_A. Then digits 1,2,3 → `disp_val` = 123 one cycle after each key (1, 12, 123).
- 1,2,+,3,4,= → one `alu_start` with `alu_a` = 12, `alu_b` = 34, `alu_op` = 0. ALU done with result 46 → `disp_val` = 46, `busy` = 0.
- Chain 5,-,2,*,3,= with a model ALU → first launch (5,2,op 1); then after done, second launch (3,3,op 2) → `disp_val` = 9.
- Digits 9,9,9,9,9 → `disp_val` = 9999 (fifth digit dropped). Then a launch where the ALU returns `alu_ovf` = 1 → `disp_err` = 1, `disp_val` = 0. Then digit 7 → `disp_err` = 0, `disp_val` = 7.
- Launch then never assert `alu_done` → `disp_err` = 1 at exactly `TIMEOUT` cycles. Keys pressed during S_WAIT cause no `alu_start` and no `disp_val` change.
- Assert `reset` while in S_WAIT, then pulse `alu_done` → outputs stay at reset values. Also check: op with `op_val` = 3, and a key pulse with no class flag → no state change.

Source files
------------

// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: builds decimal operands, launches the
// shared ALU through start/done and drives the display value and error.
module calc_ctrl #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic         is_number,
    input  logic         is_op,
    input  logic         is_eq,
    input  logic [3:0]   num_val,
    input  logic [1:0]   op_val,
    output logic         alu_start,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic [W-1:0] disp_val,
    output logic         disp_err,
    output logic         busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_A, S_OP, S_B, S_WAIT, S_RES, S_ERR
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  a_q, a_n, b_q, b_n;
    logic [W-1:0]  disp_n, alu_a_n, alu_b_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic          chain_q, chain_n;
    logic          err_n, start_n;
    logic [1:0]    op_q, op_n, pend_q, pend_n, alu_op_n;
    logic          k_dig, k_op, k_eq, full;
    logic [W-1:0]  digit, app_a, app_b;

    // Class priority: number over operator over equals.
    assign k_dig = key_valid && is_number && (num_val <= 4'd9);
    assign k_op  = key_valid && !is_number && is_op && (op_val != 2'd3);
    assign k_eq  = key_valid && !is_number && !is_op && is_eq;

    assign digit = W'(num_val);
    assign full  = (cnt_q == CW'(MAX_DIGITS));
    // Shift-in of a decimal digit; wraps modulo 2^W.
    assign app_a = a_q * W'(10) + digit;
    assign app_b = b_q * W'(10) + digit;
    assign busy  = (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            chain_q   <= 1'b0;
            op_q      <= 2'd0;
            pend_q    <= 2'd0;
            alu_start <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'd0;
            disp_val  <= '0;
            disp_err  <= 1'b0;
        end else begin
            state     <= state_n;
            a_q       <= a_n;
            b_q       <= b_n;
            cnt_q     <= cnt_n;
            tmo_q     <= tmo_n;
            chain_q   <= chain_n;
            op_q      <= op_n;
            pend_q    <= pend_n;
            alu_start <= start_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_op    <= alu_op_n;
            disp_val  <= disp_n;
            disp_err  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        cnt_n    = cnt_q;
        tmo_n    = tmo_q;
        chain_n  = chain_q;
        op_n     = op_q;
        pend_n   = pend_q;
        start_n  = 1'b0;
        alu_a_n  = alu_a;
        alu_b_n  = alu_b;
        alu_op_n = alu_op;
        disp_n   = disp_val;
        err_n    = disp_err;
        unique case (state)
            S_A: begin
                unique case (1'b1)
                    k_dig: begin
                        if (!full) begin
                            a_n    = app_a;
                            cnt_n  = cnt_q + CW'(1);
                            disp_n = app_a;
                        end
                    end
                    k_op: begin
                        op_n    = op_val;
                        state_n = S_OP;
                    end
                    default: ;
                endcase
            end
            S_OP: begin
                unique case (1'b1)
                    k_dig: begin
                        b_n     = digit;
                        cnt_n   = CW'(1);
                        disp_n  = digit;
                        state_n = S_B;
                    end
                    k_op:    op_n = op_val;
                    default: ;
                endcase
            end
            S_B: begin
                unique case (1'b1)
                    k_dig: begin
                        if (!full) begin
                            b_n    = app_b;
                            cnt_n  = cnt_q + CW'(1);
                            disp_n = app_b;
                        end
                    end
                    k_eq, k_op: begin
                        start_n  = 1'b1;
                        alu_a_n  = a_q;
                        alu_b_n  = b_q;
                        alu_op_n = op_q;
                        tmo_n    = '0;
                        chain_n  = k_op;
                        pend_n   = k_op ? op_val : pend_q;
                        state_n  = S_WAIT;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (alu_done && alu_ovf) begin
                    err_n   = 1'b1;
                    disp_n  = '0;
                    state_n = S_ERR;
                end else if (alu_done) begin
                    a_n     = alu_result;
                    disp_n  = alu_result;
                    cnt_n   = '0;
                    op_n    = chain_q ? pend_q : op_q;
                    state_n = chain_q ? S_OP : S_RES;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    disp_n  = '0;
                    state_n = S_ERR;
                end else begin
                    tmo_n = tmo_q + TW'(1);
                end
            end
            S_RES: begin
                unique case (1'b1)
                    k_dig: begin
                        a_n     = digit;
                        cnt_n   = CW'(1);
                        disp_n  = digit;
                        state_n = S_A;
                    end
                    k_op: begin
                        op_n    = op_val;
                        state_n = S_OP;
                    end
                    default: ;
                endcase
            end
            S_ERR: begin
                if (k_dig) begin
                    err_n   = 1'b0;
                    a_n     = digit;
                    cnt_n   = CW'(1);
                    disp_n  = digit;
                    state_n = S_A;
                end
            end
            default: state_n = S_A;
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: directed scenarios plus random key streams
// checked against a behavioural calculator model with its own ALU.
module tb_calc_ctrl;

    localparam int W    = 16;
    localparam int MAXD = 4;
    localparam int TO   = 1024;

    localparam int K_DIG = 0, K_OP = 1, K_EQ = 2;
    localparam int K_NONE = 3, K_BADDIG = 4, K_BADOP = 5;
    localparam int P_A = 0, P_OP = 1, P_B = 2;
    localparam int P_W = 3, P_RES = 4, P_ERR = 5;

    logic         clk, reset;
    logic         key_valid, is_number, is_op, is_eq;
    logic [3:0]   num_val;
    logic [1:0]   op_val;
    logic         alu_start;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_op;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic         alu_ovf;
    logic [W-1:0] disp_val;
    logic         disp_err, busy;

    int checks, errors;

    int m_ph, m_a, m_b, m_nd, m_op, m_pend, m_disp;
    bit m_chain, m_err, m_launch;
    int x_a, x_b, x_op;

    calc_ctrl #(.W(W), .MAX_DIGITS(MAXD), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .is_number(is_number),
        .is_op(is_op), .is_eq(is_eq),
        .num_val(num_val), .op_val(op_val),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_done(alu_done),
        .alu_result(alu_result), .alu_ovf(alu_ovf),
        .disp_val(disp_val), .disp_err(disp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int app(input int v, input int d);
        return (v * 10 + d) % 65536;
    endfunction

    task automatic model_reset();
        m_ph = P_A; m_a = 0; m_b = 0; m_nd = 0; m_op = 0;
        m_pend = 0; m_disp = 0; m_chain = 0; m_err = 0; m_launch = 0;
    endtask

    task automatic model_key(input int kind, input int v, output bit launch);
        launch = 0;
        case (m_ph)
            P_A: begin
                if (kind == K_DIG) begin
                    if (m_nd < MAXD) begin m_a = app(m_a, v); m_nd++; end
                    m_disp = m_a;
                end else if (kind == K_OP) begin
                    m_op = v; m_ph = P_OP;
                end
            end
            P_OP: begin
                if (kind == K_DIG) begin
                    m_b = v; m_nd = 1; m_disp = v; m_ph = P_B;
                end else if (kind == K_OP) begin
                    m_op = v;
                end
            end
            P_B: begin
                if (kind == K_DIG) begin
                    if (m_nd < MAXD) begin m_b = app(m_b, v); m_nd++; end
                    m_disp = m_b;
                end else if (kind == K_EQ || kind == K_OP) begin
                    x_a = m_a; x_b = m_b; x_op = m_op; launch = 1;
                    m_chain = (kind == K_OP);
                    if (kind == K_OP) m_pend = v;
                    m_ph = P_W;
                end
            end
            P_RES: begin
                if (kind == K_DIG) begin
                    m_a = v; m_nd = 1; m_disp = v; m_ph = P_A;
                end else if (kind == K_OP) begin
                    m_op = v; m_ph = P_OP;
                end
            end
            P_ERR: begin
                if (kind == K_DIG) begin
                    m_err = 0; m_a = v; m_nd = 1; m_disp = v; m_ph = P_A;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_done(input int res, input bit ovf);
        if (m_ph != P_W) return;
        if (ovf) begin
            m_err = 1; m_disp = 0; m_ph = P_ERR;
        end else begin
            m_a = res; m_disp = res; m_nd = 0;
            if (m_chain) begin m_op = m_pend; m_ph = P_OP; end
            else m_ph = P_RES;
        end
    endtask

    task automatic alu_calc(input int a, input int b, input int op,
                            output int res, output bit ovf);
        longint f;
        case (op)
            0: begin f = longint'(a) + b; ovf = (f > 65535); end
            1: begin f = longint'(a) - b; ovf = (a < b); end
            default: begin f = longint'(a) * b; ovf = (f > 65535); end
        endcase
        res = int'(f & 65535);
    endtask

    task automatic clear_inputs();
        key_valid = 0; is_number = 0; is_op = 0; is_eq = 0;
        num_val = 0; op_val = 0;
        alu_done = 0; alu_result = 0; alu_ovf = 0;
    endtask

    task automatic drive_key(input int kind, input int v);
        bit l;
        clear_inputs();
        key_valid = 1;
        case (kind)
            K_DIG: begin
                is_number = 1; num_val = 4'(v);
                is_eq = 1'($urandom_range(0, 1));
            end
            K_OP: begin
                is_op = 1; op_val = 2'(v);
                is_eq = 1'($urandom_range(0, 1));
            end
            K_EQ: is_eq = 1;
            K_BADDIG: begin
                is_number = 1; is_op = 1; num_val = 4'(10 + v % 6);
            end
            K_BADOP: begin is_op = 1; is_eq = 1; op_val = 2'd3; end
            default: ;
        endcase
        model_key(kind, v, l);
        m_launch = l;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic pulse_done(input int res, input bit ovf, input bit junk);
        clear_inputs();
        alu_done = 1; alu_result = W'(res); alu_ovf = ovf;
        if (junk) begin
            key_valid = 1; is_number = 1;
            num_val = 4'($urandom_range(0, 9));
        end
        model_done(res, ovf);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({disp_val, disp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_disp: val=%0d err=%b busy=%b want 0 0 0",
                     disp_val, disp_err, busy);
        end
        checks++;
        if ({alu_start, alu_a, alu_b, alu_op} !== '0) begin
            errors++;
            $display("FAIL reset_alu: start=%b a=%0d b=%0d op=%0d want 0",
                     alu_start, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_digits();
        int exp[3];
        exp = '{1, 12, 123};
        for (int i = 0; i < 3; i++) begin
            drive_key(K_DIG, i + 1);
            checks++;
            if (disp_val !== W'(exp[i])) begin
                errors++;
                $display("FAIL digits[%0d]: disp_val=%0d want %0d",
                         i, disp_val, exp[i]);
            end
        end
    endtask

    task automatic test_add();
        do_reset();
        drive_key(K_DIG, 1); drive_key(K_DIG, 2); drive_key(K_OP, 0);
        drive_key(K_DIG, 3); drive_key(K_DIG, 4); drive_key(K_EQ, 0);
        checks++;
        if ({alu_start, busy, alu_a, alu_b, alu_op} !==
            {1'b1, 1'b1, W'(12), W'(34), 2'd0}) begin
            errors++;
            $display("FAIL add_launch: start=%b busy=%b a=%0d b=%0d op=%0d want 1 1 12 34 0",
                     alu_start, busy, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b0 || alu_a !== W'(12)) begin
            errors++;
            $display("FAIL add_pulse: start=%b a=%0d want 0 12", alu_start, alu_a);
        end
        pulse_done(46, 0, 0);
        checks++;
        if ({busy, disp_err, disp_val} !== {1'b0, 1'b0, W'(46)}) begin
            errors++;
            $display("FAIL add_result: busy=%b err=%b disp=%0d want 0 0 46",
                     busy, disp_err, disp_val);
        end
    endtask

    task automatic test_chain();
        int r; bit o;
        do_reset();
        drive_key(K_DIG, 5); drive_key(K_OP, 1);
        drive_key(K_DIG, 2); drive_key(K_OP, 2);
        checks++;
        if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, W'(5), W'(2), 2'd1}) begin
            errors++;
            $display("FAIL chain_launch1: start=%b a=%0d b=%0d op=%0d want 1 5 2 1",
                     alu_start, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        alu_calc(x_a, x_b, x_op, r, o);
        pulse_done(r, o, 0);
        checks++;
        if (disp_val !== W'(3) || busy !== 1'b0) begin
            errors++;
            $display("FAIL chain_mid: disp=%0d busy=%b want 3 0", disp_val, busy);
        end
        drive_key(K_DIG, 3); drive_key(K_EQ, 0);
        checks++;
        if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, W'(3), W'(3), 2'd2}) begin
            errors++;
            $display("FAIL chain_launch2: start=%b a=%0d b=%0d op=%0d want 1 3 3 2",
                     alu_start, alu_a, alu_b, alu_op);
        end
        repeat (2) @(negedge clk);
        alu_calc(x_a, x_b, x_op, r, o);
        pulse_done(r, o, 0);
        checks++;
        if (disp_val !== W'(9)) begin
            errors++;
            $display("FAIL chain_result: disp=%0d want 9", disp_val);
        end
    endtask

    task automatic test_overflow();
        int r; bit o;
        do_reset();
        for (int i = 0; i < 5; i++) drive_key(K_DIG, 9);
        checks++;
        if (disp_val !== W'(9999)) begin
            errors++;
            $display("FAIL max_digits: disp=%0d want 9999", disp_val);
        end
        drive_key(K_OP, 2);
        for (int i = 0; i < 4; i++) drive_key(K_DIG, 9);
        drive_key(K_EQ, 0);
        @(negedge clk);
        alu_calc(x_a, x_b, x_op, r, o);
        pulse_done(r, o, 0);
        checks++;
        if ({disp_err, disp_val} !== {1'b1, W'(0)}) begin
            errors++;
            $display("FAIL ovf_err: err=%b disp=%0d want 1 0", disp_err, disp_val);
        end
        drive_key(K_DIG, 7);
        checks++;
        if ({disp_err, disp_val} !== {1'b0, W'(7)}) begin
            errors++;
            $display("FAIL err_clear: err=%b disp=%0d want 0 7", disp_err, disp_val);
        end
    endtask

    task automatic test_timeout();
        int got;
        got = -1;
        do_reset();
        drive_key(K_DIG, 1); drive_key(K_OP, 0);
        drive_key(K_DIG, 2); drive_key(K_EQ, 0);
        for (int k = 1; k <= TO + 8; k++) begin
            if (k >= 2 && k <= 6) drive_key((k % 2 == 0) ? K_DIG : K_EQ, 3);
            else @(negedge clk);
            if (disp_err === 1'b1) begin got = k; break; end
            checks++;
            if (alu_start !== 1'b0 || disp_val !== W'(m_disp)) begin
                errors++;
                $display("FAIL wait_keys[%0d]: start=%b disp=%0d want 0 %0d",
                         k, alu_start, disp_val, m_disp);
            end
        end
        checks++;
        if (got != TO) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want %0d", got, TO);
        end
        m_err = 1; m_disp = 0; m_ph = P_ERR;
        checks++;
        if (disp_val !== W'(0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_disp: disp=%0d busy=%b want 0 0", disp_val, busy);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive_key(K_DIG, 4); drive_key(K_OP, 0);
        drive_key(K_DIG, 5); drive_key(K_EQ, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        pulse_done(9, 0, 0);
        @(negedge clk);
        checks++;
        if ({disp_val, disp_err, busy, alu_start, alu_a, alu_b, alu_op} !== '0) begin
            errors++;
            $display("FAIL stale_done: disp=%0d err=%b busy=%b start=%b a=%0d b=%0d want 0",
                     disp_val, disp_err, busy, alu_start, alu_a, alu_b);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        drive_key(K_DIG, 4);
        drive_key(K_NONE, 0); drive_key(K_BADDIG, 3); drive_key(K_BADOP, 0);
        drive_key(K_DIG, 5);
        checks++;
        if (disp_val !== W'(45)) begin
            errors++;
            $display("FAIL ignore_a: disp=%0d want 45", disp_val);
        end
        drive_key(K_OP, 1); drive_key(K_BADOP, 0);
        drive_key(K_DIG, 6); drive_key(K_EQ, 0);
        checks++;
        if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, W'(45), W'(6), 2'd1}) begin
            errors++;
            $display("FAIL ignore_op: start=%b a=%0d b=%0d op=%0d want 1 45 6 1",
                     alu_start, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        pulse_done(39, 0, 0);
    endtask

    task automatic test_random();
        int r, kind, v, d, res;
        bit o;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            kind = (r < 50) ? K_DIG : (r < 70) ? K_OP : (r < 85) ? K_EQ :
                   (r < 90) ? K_NONE : (r < 95) ? K_BADDIG : K_BADOP;
            v = (kind == K_OP) ? $urandom_range(0, 2) : $urandom_range(0, 9);
            drive_key(kind, v);
            checks++;
            if ({disp_err, disp_val, alu_start} !== {m_err, W'(m_disp), m_launch}) begin
                errors++;
                $display("FAIL rand_key[%0d]: err=%b disp=%0d start=%b want %b %0d %b",
                         i, disp_err, disp_val, alu_start, m_err, m_disp, m_launch);
            end
            if (m_launch) begin
                checks++;
                if ({alu_a, alu_b, alu_op} !== {W'(x_a), W'(x_b), 2'(x_op)}) begin
                    errors++;
                    $display("FAIL rand_launch[%0d]: a=%0d b=%0d op=%0d want %0d %0d %0d",
                             i, alu_a, alu_b, alu_op, x_a, x_b, x_op);
                end
                d = $urandom_range(1, 4);
                for (int j = 0; j < d; j++) begin
                    drive_key($urandom_range(0, 5), $urandom_range(0, 2));
                    checks++;
                    if ({alu_start, busy, disp_val, alu_a, alu_b} !==
                        {1'b0, 1'b1, W'(m_disp), W'(x_a), W'(x_b)}) begin
                        errors++;
                        $display("FAIL rand_wait[%0d]: start=%b busy=%b disp=%0d a=%0d b=%0d",
                                 i, alu_start, busy, disp_val, alu_a, alu_b);
                    end
                end
                alu_calc(x_a, x_b, x_op, res, o);
                pulse_done(res, o, 1'($urandom_range(0, 1)));
                checks++;
                if ({busy, disp_err, disp_val} !== {1'b0, m_err, W'(m_disp)}) begin
                    errors++;
                    $display("FAIL rand_done[%0d]: busy=%b err=%b disp=%0d want 0 %b %0d",
                             i, busy, disp_err, disp_val, m_err, m_disp);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1;
        clear_inputs();
        model_reset();
        test_reset();
        test_digits();
        test_add();
        test_chain();
        test_overflow();
        test_timeout();
        test_reset_in_wait();
        test_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
